// File: rtl/stopwatch_display.sv
// Four-digit multiplexed seven-segment driver for the stopwatch minutes/seconds values.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank the minutes-tens digit below 10 minutes.
module stopwatch_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [RW-1:0] ref_cnt;
  logic [1:0]    idx;
  logic [5:0]    snap_min;
  logic [5:0]    snap_sec;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          sel_q;
  logic          slot_end;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
    return {tens, ones};
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign slot_end = (ref_cnt == RW'(REFRESH_DIV - 1));

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt  <= '0;
      idx      <= 2'd0;
      snap_min <= 6'd0;
      snap_sec <= 6'd0;
      sel_q    <= 1'b0;
    end else if (slot_end) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
      sel_q   <= sel;
      // Capture the whole frame at once so the four digits never tear.
      if (idx == 2'd3) begin
        snap_min <= minutes;
        snap_sec <= seconds;
      end
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !adj) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [3:0] digit;
  logic       blank;

  assign min_bcd = to_bcd(snap_min);
  assign sec_bcd = to_bcd(snap_sec);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    digit = 4'd0;
    case (idx)
      2'd0: digit = sec_bcd[3:0];
      2'd1: digit = sec_bcd[7:4];
      2'd2: digit = min_bcd[3:0];
      2'd3: digit = min_bcd[7:4];
      default: digit = 4'd0;
    endcase
  end

  // sel_q = 0 selects the minutes pair (idx[1] = 1), sel_q = 1 the seconds pair.
  always_comb begin
    blank = adj && blink_phase && (sel_q ? ~idx[1] : idx[1]);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 2'd3 && snap_min < 6'd10) blank = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || blank) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= {1'b1, encode(digit)};
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed self-checking bench for stopwatch_display with REFRESH_DIV=4, BLINK_DIV=16.
module tb_stopwatch_display;

  localparam int R = 4;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       adj;
  logic       sel;
  logic [3:0] an;
  logic [7:0] seg;

  int total = 0;
  int bad   = 0;
  int two_low = 0;

  stopwatch_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .minutes(minutes), .seconds(seconds),
    .adj(adj), .sel(sel), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the first negedge at which a fresh slot 0 has just appeared.
  task automatic wait_frame_start();
    logic [3:0] prev;
    bit found;
    prev = an;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev != 4'b1110) found = 1;
      prev = an;
    end
    if (!found) check("frame_start_timeout", 8'd0, 8'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3, input logic [3:0] an3);
    wait_frame_start();
    check({tag, "_an0"}, 8'(an), 8'h0E);
    check({tag, "_seg0"}, seg, s0);
    repeat (R) @(negedge clk);
    check({tag, "_an1"}, 8'(an), 8'h0D);
    check({tag, "_seg1"}, seg, s1);
    repeat (R) @(negedge clk);
    check({tag, "_an2"}, 8'(an), 8'h0B);
    check({tag, "_seg2"}, seg, s2);
    repeat (R) @(negedge clk);
    check({tag, "_an3"}, 8'(an), 8'(an3));
    check({tag, "_seg3"}, seg, s3);
  endtask

  // Count, per digit, the cycles its anode is low over a window.
  task automatic count_low(input int cycles, output int c0, output int c1,
                           output int c2, output int c3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (!an[0]) c0++;
      if (!an[1]) c1++;
      if (!an[2]) c2++;
      if (!an[3]) c3++;
      if ($countones(~an) > 1) two_low++;
    end
  endtask

  int c0, c1, c2, c3;

  initial begin
    rst = 1'b1; minutes = 6'd12; seconds = 6'd34; adj = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Reset mid-scan, then restart from slot 0 showing the zeroed snapshot.
    rst = 1'b1;
    @(negedge clk);
    check("rst_an", 8'(an), 8'h0F);
    check("rst_seg", seg, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_an0", 8'(an), 8'h0E);
    check("post_rst_seg0", seg, 8'hC0);
    repeat (R) @(negedge clk);
    check("post_rst_an1", 8'(an), 8'h0D);
    check("post_rst_seg1", seg, 8'hC0);

    // Static value 12:34.
    repeat (2) @(negedge clk);
    check_frame("static", 8'h99, 8'hB0, 8'hA4, 8'hF9, 4'b0111);

    // Coherence: inputs change during slot 1, rest of frame keeps 12:34.
    wait_frame_start();
    check("coh_seg0", seg, 8'h99);
    repeat (R) @(negedge clk);
    check("coh_seg1", seg, 8'hB0);
    seconds = 6'd35; minutes = 6'd45;
    repeat (R) @(negedge clk);
    check("coh_seg2_old", seg, 8'hA4);
    repeat (R) @(negedge clk);
    check("coh_seg3_old", seg, 8'hF9);
    repeat (R) @(negedge clk);
    check("coh_an0_new", 8'(an), 8'h0E);
    check("coh_seg0_new", seg, 8'h92);
    repeat (R) @(negedge clk);
    check("coh_seg1_new", seg, 8'hB0);
    repeat (R) @(negedge clk);
    check("coh_seg2_new", seg, 8'h92);
    repeat (R) @(negedge clk);
    check("coh_seg3_new", seg, 8'h99);

    // Out-of-range decimal display 63:60.
    minutes = 6'd63; seconds = 6'd60;
    repeat (2) @(negedge clk);
    check_frame("range", 8'hC0, 8'h82, 8'hB0, 8'h82, 4'b0111);

    // Leading-zero handling of minutes-tens.
    minutes = 6'd5; seconds = 6'd34;
    repeat (2) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("lz5", 8'h99, 8'hB0, 8'h92, 8'hFF, 4'b1111);
    count_low(16, c0, c1, c2, c3);
    check("lz5_an3_low_count", 8'(c3), 8'd0);
`else
    check_frame("lz5", 8'h99, 8'hB0, 8'h92, 8'hC0, 4'b0111);
`endif
    minutes = 6'd10;
    repeat (2) @(negedge clk);
    check_frame("lz10", 8'h99, 8'hB0, 8'hC0, 8'hF9, 4'b0111);

    // Blink minutes pair.
    minutes = 6'd12; seconds = 6'd34;
    repeat (20) @(negedge clk);
    adj = 1'b1; sel = 1'b0;
    repeat (4) @(negedge clk);
    count_low(64, c0, c1, c2, c3);
    check("blink_m_c0", 8'(c0), 8'd16);
    check("blink_m_c1", 8'(c1), 8'd16);
    check("blink_m_c2", 8'(c2), 8'd8);
    check("blink_m_c3", 8'(c3), 8'd8);

    // Blink seconds pair.
    sel = 1'b1;
    repeat (8) @(negedge clk);
    count_low(64, c0, c1, c2, c3);
    check("blink_s_c0", 8'(c0), 8'd8);
    check("blink_s_c1", 8'(c1), 8'd8);
    check("blink_s_c2", 8'(c2), 8'd16);
    check("blink_s_c3", 8'(c3), 8'd16);

    // Drop adj: every digit visible again.
    adj = 1'b0;
    repeat (18) @(negedge clk);
    count_low(16, c0, c1, c2, c3);
    check("noadj_c0", 8'(c0), 8'd4);
    check("noadj_c1", 8'(c1), 8'd4);
    check("noadj_c2", 8'(c2), 8'd4);
    check("noadj_c3", 8'(c3), 8'd4);
    check("two_anodes_low", 8'(two_low), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
